// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit serial link.
// Holds the transmitter state encoding and the line levels, which the
// capture side uses too.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic SERIAL_IDLE_LVL = 1'b1;
  localparam logic START_LVL       = 1'b0;
  localparam logic STOP_LVL        = 1'b1;

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled. It pulses bit_tick on the last
// cycle of each bit period.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (frame accept), realigns the bit period
//   en       : count enable (frame in flight)
//   bit_tick : high during the final cycle of a bit period
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // With CLKS_PER_BIT=1, LAST is 0, so every enabled cycle ticks.
  assign bit_tick = en & (cnt == LAST);

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial frame transmitter.
// A frame is a start bit, then DATA_W data bits LSB-first, then an optional
// parity bit, then STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk, rst : clock, async active-high reset (abandons any frame in flight)
//   tx_data  : word to send, latched on accept
//   tx_valid : source has a word
//   tx_ready : transmitter can accept (accept = tx_valid & tx_ready)
//   tx_out   : serial line, idle high
//   tx_busy  : a frame is on the line
//   tx_done  : one-cycle pulse after the last stop bit
// All outputs are registered. Each next line level is decided with the
// state transition that produces it, so tx_out changes on the same edge as
// the state.
module serial_tx_shifter
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int             BCW       = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_e       state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_nxt;
  logic [BCW-1:0]  bit_cnt;
  logic            parity_bit;
  logic            accept;
  logic            bit_tick;

  assign accept = tx_valid & tx_ready;
  // Shifted copy of the word. Its LSB is the next data bit to drive.
  assign sh_nxt = shreg >> 1;

  bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bpc (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_out     <= SERIAL_IDLE_LVL;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out   <= SERIAL_IDLE_LVL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          if (accept) begin
            shreg      <= tx_data;
            // Parity is taken from the word as latched.
            parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
            bit_cnt    <= '0;
            state      <= START;
            tx_out     <= START_LVL;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            tx_out  <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg <= sh_nxt;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                tx_out <= parity_bit;
              end else begin
                state  <= STOP;
                tx_out <= STOP_LVL;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= sh_nxt[0];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state   <= STOP;
            tx_out  <= STOP_LVL;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state    <= IDLE;
              bit_cnt  <= '0;
              tx_out   <= SERIAL_IDLE_LVL;
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          // An encoding outside the enum returns the line to idle.
          state    <= IDLE;
          bit_cnt  <= '0;
          tx_out   <= SERIAL_IDLE_LVL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter. It builds four configurations:
//   d0: 8N1, CLKS_PER_BIT=4
//   d1: 8E1, CLKS_PER_BIT=4
//   d2: 8O1, CLKS_PER_BIT=4
//   d3: 8N2, CLKS_PER_BIT=1
// Expected line sequences are written by hand as vectors. Bit k of a vector
// is the k-th serial bit on the line.
module tb_serial_tx_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data [4];
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx_out;
  logic [3:0] tx_busy;
  logic [3:0] tx_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
  serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .tx_out(tx_out[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in cycle 1 of a frame, one cycle after the accept edge.
  // Checks every cycle of the frame and ends in the cycle after the frame.
  task automatic check_line(input int d, input logic [15:0] seq, input int nbits,
                            input int cpb, input string tag);
    for (int c = 0; c < nbits * cpb; c++) begin
      chk({tag, "_line"}, 32'(tx_out[d]), 32'(seq[c / cpb]));
      chk({tag, "_busy"}, 32'(tx_busy[d]), 32'd1);
      chk({tag, "_nodone"}, 32'(tx_done[d]), 32'd0);
      step();
    end
  endtask

  task automatic check_done(input int d, input string tag);
    chk({tag, "_done"}, 32'(tx_done[d]), 32'd1);
    chk({tag, "_ready"}, 32'(tx_ready[d]), 32'd1);
    chk({tag, "_idlebusy"}, 32'(tx_busy[d]), 32'd0);
    chk({tag, "_idleline"}, 32'(tx_out[d]), 32'd1);
  endtask

  task automatic send(input int d, input logic [7:0] w);
    tx_data[d]  = w;
    tx_valid[d] = 1'b1;
    step();
    tx_valid[d] = 1'b0;
    chk("accept_ready_low", 32'(tx_ready[d]), 32'd0);
  endtask

  initial begin
    tx_valid = '0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

    // Reset values
    step();
    step();
    chk("rst_out", 32'(tx_out), 32'hF);
    chk("rst_ready", 32'(tx_ready), 32'hF);
    chk("rst_busy", 32'(tx_busy), 32'h0);
    chk("rst_done", 32'(tx_done), 32'h0);
    rst = 1'b0;
    step();
    chk("idle_out", 32'(tx_out), 32'hF);

    // 0xA5, 8N1, 4 clk/bit. tx_done is expected in cycle 41.
    send(0, 8'hA5);
    check_line(0, 16'b1101001010, 10, 4, "a5");
    check_done(0, "a5");
    step();
    chk("a5_done_once", 32'(tx_done[0]), 32'd0);

    // 0xA5 with even parity (bit 0), then odd parity (bit 1). Frame is 44 cycles.
    send(1, 8'hA5);
    check_line(1, 16'b10101001010, 11, 4, "even");
    check_done(1, "even");
    send(2, 8'hA5);
    check_line(2, 16'b11101001010, 11, 4, "odd");
    check_done(2, "odd");

    // Back-to-back. tx_valid stays high. 0xFF is held off until the tx_done cycle.
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    step();
    tx_data[0]  = 8'hFF;
    check_line(0, 16'b1000000000, 10, 4, "b2b0");
    check_done(0, "b2b0");
    step();
    tx_valid[0] = 1'b0;
    chk("b2b_start_line", 32'(tx_out[0]), 32'd0);
    chk("b2b_start_ready", 32'(tx_ready[0]), 32'd0);
    check_line(0, 16'b1111111110, 10, 4, "b2b1");
    check_done(0, "b2b1");
    step();

    // tx_data changes mid-frame. The line still carries 0x3C.
    send(0, 8'h3C);
    tx_data[0] = 8'hC3;
    check_line(0, 16'b1001111000, 10, 4, "hold3c");
    check_done(0, "hold3c");
    step();

    // 8N2 at 1 clk/bit, data 0x01.
    send(3, 8'h01);
    check_line(3, 16'b11000000010, 11, 1, "n2");
    check_done(3, "n2");
    step();

    // Reset during data bit 3 (cycles 17..20). Bit 3 of 0xA5 is 0.
    send(0, 8'hA5);
    for (int i = 0; i < 17; i++) step();
    chk("mid_bit3", 32'(tx_out[0]), 32'd0);
    chk("mid_busy", 32'(tx_busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(tx_out[0]), 32'd1);
    chk("arst_busy", 32'(tx_busy[0]), 32'd0);
    chk("arst_ready", 32'(tx_ready[0]), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("post_rst_nodone", 32'(tx_done[0]), 32'd0);
      chk("post_rst_line", 32'(tx_out[0]), 32'd1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
